ysyx_22050612_regfile_sb: RTL and testbench

Parametrised general-purpose register file with an integrated scoreboard, used as the integer register file of the ysyx_22050612 core between decode (reads, destination reservation) and writeback (result commit). Provides two asynchronous read ports, one synchronous write port, an optional hardwired zero register, and per-register busy tracking so decode can detect read-after-write hazards. Optional same-cycle write-to-read forwarding is selected at compile time.

---
 rtl/ysyx_22050612_regfile_sb.sv | 97 +++++++++
 tb/tb_ysyx_22050612_regfile_sb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_regfile_sb.sv
// Integer register file with per-register busy scoreboard for decode hazard detection.
// Define YSYX_22050612_RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module ysyx_22050612_regfile_sb #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  alloc_en,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] src1,
  output logic [DATA_WIDTH-1:0] src2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  any_busy
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [Depth];
  logic [DATA_WIDTH-1:0] rf_d [Depth];
  logic [Depth-1:0]      busy_q, busy_d;

  logic wr_ok, alloc_ok;

  assign wr_ok    = wen && !((ZERO_REG != 0) && (waddr == '0));
  assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

  // Alloc is applied after the write so a same-index collision leaves the register busy.
  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    if (wr_ok) begin
      rf_d[waddr]   = wdata;
      busy_d[waddr] = 1'b0;
    end
    if (alloc_ok) begin
      busy_d[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        rf_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_data(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = rf_q[idx];
`ifdef YSYX_22050612_RF_BYPASS_EN
    if (wen && (waddr == idx)) begin
      val = wdata;
    end
`endif
    if (rst || ((ZERO_REG != 0) && (idx == '0))) begin
      val = '0;
    end
    return val;
  endfunction

  function automatic logic read_busy(input logic [ADDR_WIDTH-1:0] idx);
    logic b;
    b = busy_q[idx];
`ifdef YSYX_22050612_RF_BYPASS_EN
    // A producer allocated in the same cycle keeps the stored busy bit visible.
    if (wen && (waddr == idx) && !(alloc_en && (alloc_addr == idx))) begin
      b = 1'b0;
    end
`endif
    if (rst || ((ZERO_REG != 0) && (idx == '0))) begin
      b = 1'b0;
    end
    return b;
  endfunction

  always_comb begin
    src1     = read_data(rs1);
    src2     = read_data(rs2);
    rs1_busy = read_busy(rs1);
    rs2_busy = read_busy(rs2);
    any_busy = |busy_q;
  end

endmodule

// File: tb/tb_ysyx_22050612_regfile_sb.sv
// Self-checking bench for ysyx_22050612_regfile_sb: vector table through a scoreboard queue,
// plus hand-written asynchronous reset sequences. Honours YSYX_22050612_RF_BYPASS_EN.
module tb_ysyx_22050612_regfile_sb;

`ifdef YSYX_22050612_RF_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [4:0]  rs1, rs2;
  logic [63:0] src1, src2;
  logic        rs1_busy, rs2_busy, any_busy;

  int errors = 0;
  int checks = 0;

  ysyx_22050612_regfile_sb #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(64),
    .ZERO_REG  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .rs1       (rs1),
    .rs2       (rs2),
    .src1      (src1),
    .src2      (src2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .any_busy  (any_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } stim_t;

  typedef struct packed {
    logic [63:0] src1;
    logic [63:0] src2;
    logic        b1;
    logic        b2;
    logic        any;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam int NumVec = 16;
  localparam logic [63:0] Big = 64'h1234_5678_9ABC_DEF0;

  vec_t vecs [NumVec];
  exp_t sb_q [$];

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                              input logic a, input logic [4:0] aa,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [63:0] e1, input logic [63:0] e2,
                              input logic b1, input logic b2, input logic an);
    vec_t v;
    v.s = '{wen: w, waddr: wa, wdata: wd, alloc_en: a, alloc_addr: aa, rs1: r1, rs2: r2};
    v.e = '{src1: e1, src2: e2, b1: b1, b2: b2, any: an};
    return v;
  endfunction

  task automatic drive(input stim_t s);
    wen        = s.wen;
    waddr      = s.waddr;
    wdata      = s.wdata;
    alloc_en   = s.alloc_en;
    alloc_addr = s.alloc_addr;
    rs1        = s.rs1;
    rs2        = s.rs2;
  endtask

  task automatic check(input string name, input exp_t e);
    checks += 5;
    if (src1 !== e.src1) begin
      errors++;
      $display("FAIL %s src1: got %h want %h", name, src1, e.src1);
    end
    if (src2 !== e.src2) begin
      errors++;
      $display("FAIL %s src2: got %h want %h", name, src2, e.src2);
    end
    if (rs1_busy !== e.b1) begin
      errors++;
      $display("FAIL %s rs1_busy: got %b want %b", name, rs1_busy, e.b1);
    end
    if (rs2_busy !== e.b2) begin
      errors++;
      $display("FAIL %s rs2_busy: got %b want %b", name, rs2_busy, e.b2);
    end
    if (any_busy !== e.any) begin
      errors++;
      $display("FAIL %s any_busy: got %b want %b", name, any_busy, e.any);
    end
  endtask

  initial begin
    exp_t e;
    // Each row: inputs held for one cycle, outputs expected mid-cycle.
    vecs[0]  = mk(1, 5, 64'hDEAD_BEEF, 0, 0, 5, 4, Byp ? 64'hDEAD_BEEF : 64'h0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 5, 4, 64'hDEAD_BEEF, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 64'h1234, 1, 0, 0, 5, 0, 64'hDEAD_BEEF, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 7, 5, 7, 64'hDEAD_BEEF, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 7, 7, 0, 0, 1, 1, 1);
    vecs[6]  = mk(1, 7, 64'h55, 0, 0, 7, 7, Byp ? 64'h55 : 64'h0, Byp ? 64'h55 : 64'h0,
                  !Byp, !Byp, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 7, 5, 64'h55, 64'hDEAD_BEEF, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 3, 3, 3, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 3, 64'hAA, 1, 3, 3, 7, Byp ? 64'hAA : 64'h0, 64'h55, 1, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 3, 3, 64'hAA, 64'hAA, 1, 1, 1);
    vecs[11] = mk(1, 9, 64'h77, 0, 0, 9, 3, Byp ? 64'h77 : 64'h0, 64'hAA, 0, 1, 1);
    vecs[12] = mk(1, 3, 64'hBB, 1, 8, 9, 8, 64'h77, 0, 0, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 3, 8, 64'hBB, 0, 0, 1, 1);
    vecs[14] = mk(1, 8, Big, 0, 0, 8, 5, Byp ? Big : 64'h0, 64'hDEAD_BEEF, !Byp, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 8, 0, Big, 0, 0, 0, 0);

    rst = 1'b1;
    drive('{wen: 0, waddr: 0, wdata: 0, alloc_en: 0, alloc_addr: 0, rs1: 5, rs2: 7});
    #2;
    check("reset_state", '{src1: 0, src2: 0, b1: 0, b2: 0, any: 0});
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].s);
      sb_q.push_back(vecs[i].e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL vec%0d scoreboard: got empty queue want entry", i);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("vec%0d", i), e);
      end
    end

    // Make register 4 busy, then assert reset between edges with writes pending.
    @(posedge clk);
    #1;
    drive('{wen: 0, waddr: 0, wdata: 0, alloc_en: 1, alloc_addr: 4, rs1: 4, rs2: 5});
    @(posedge clk);
    #1;
    drive('{wen: 0, waddr: 0, wdata: 0, alloc_en: 0, alloc_addr: 0, rs1: 4, rs2: 5});
    check("pre_reset", '{src1: 0, src2: 64'hDEAD_BEEF, b1: 1, b2: 0, any: 1});
    #2;
    drive('{wen: 1, waddr: 5, wdata: 64'hFFFF, alloc_en: 1, alloc_addr: 6, rs1: 3, rs2: 5});
    rst = 1'b1;
    #1;
    check("async_reset", '{src1: 0, src2: 0, b1: 0, b2: 0, any: 0});
    @(posedge clk);
    #1;
    rs1 = 6;
    check("reset_held", '{src1: 0, src2: 0, b1: 0, b2: 0, any: 0});
    @(negedge clk);
    rst = 1'b0;
    drive('{wen: 0, waddr: 0, wdata: 0, alloc_en: 0, alloc_addr: 0, rs1: 6, rs2: 5});
    @(posedge clk);
    #1;
    check("post_reset", '{src1: 0, src2: 0, b1: 0, b2: 0, any: 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
